// File: rtl/sap16_core.sv
// 16-bit SAP-style accumulator computer: PC, IR, accumulator, Z/C flags, two-phase control FSM and a 256x16 RAM.
// Optional feature macro: SAP_DEBUG_EN (drives debug = {PC, IR opcode}; otherwise debug is tied to zero).

module sap16_ram #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  // NOTE: the storage array has no reset; program images are preloaded and must survive rst.
  reg [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

module sap16_core #(
  parameter int            AW       = 8,
  parameter int            DW       = 16,
  parameter logic [AW-1:0] RESET_PC = 8'h0A
) (
  input  logic          clk,
  input  logic          rst,
  output logic [DW-1:0] _out_,
  output logic [DW-1:0] debug
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam logic [7:0] OP_LDA = 8'h00;
  localparam logic [7:0] OP_STA = 8'h01;
  localparam logic [7:0] OP_ADD = 8'h02;
  localparam logic [7:0] OP_SUB = 8'h03;
  localparam logic [7:0] OP_AND = 8'h04;
  localparam logic [7:0] OP_OR  = 8'h05;
  localparam logic [7:0] OP_XOR = 8'h06;
  localparam logic [7:0] OP_LDI = 8'h07;
  localparam logic [7:0] OP_JMP = 8'h08;
  localparam logic [7:0] OP_JZ  = 8'h09;
  localparam logic [7:0] OP_JC  = 8'h0A;
  localparam logic [7:0] OP_OUT = 8'h0B;
  localparam logic [7:0] OP_HLT = 8'hFF;

  state_t        state;
  logic [AW-1:0] pc;
  logic [DW-1:0] ir;
  logic [DW-1:0] acc;
  logic          z_flag;
  logic          c_flag;

  logic [7:0]    opcode;
  logic [AW-1:0] operand;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          mem_we;

  assign opcode  = ir[DW-1:DW-8];
  assign operand = ir[AW-1:0];

  // One shared RAM port: the PC addresses it while fetching, the operand while executing.
  assign mem_addr = (state == S_FETCH) ? pc : operand;
  assign mem_we   = (state == S_EXEC) && (opcode == OP_STA) && !rst;

  sap16_ram #(.AW(AW), .DW(DW)) ram1 (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (acc),
    .rdata (mem_rdata)
  );

  logic [DW:0]   sum;
  logic [DW:0]   diff;
  logic [DW-1:0] alu_res;
  logic          alu_carry;
  logic          acc_we;
  logic          carry_we;

  assign sum  = {1'b0, acc} + {1'b0, mem_rdata};
  assign diff = {1'b0, acc} - {1'b0, mem_rdata};

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    alu_res   = acc;
    alu_carry = c_flag;
    acc_we    = 1'b0;
    carry_we  = 1'b0;
    case (opcode)
      OP_LDA: begin alu_res = mem_rdata;        acc_we = 1'b1; end
      OP_AND: begin alu_res = acc & mem_rdata;  acc_we = 1'b1; end
      OP_OR:  begin alu_res = acc | mem_rdata;  acc_we = 1'b1; end
      OP_XOR: begin alu_res = acc ^ mem_rdata;  acc_we = 1'b1; end
      OP_LDI: begin alu_res = {{(DW-AW){1'b0}}, operand}; acc_we = 1'b1; end
      OP_ADD: begin
        alu_res   = sum[DW-1:0];
        alu_carry = sum[DW];
        acc_we    = 1'b1;
        carry_we  = 1'b1;
      end
      OP_SUB: begin
        // Carry means "no borrow", i.e. acc >= operand.
        alu_res   = diff[DW-1:0];
        alu_carry = ~diff[DW];
        acc_we    = 1'b1;
        carry_we  = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: all state registers use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_FETCH;
      pc     <= RESET_PC;
      ir     <= '0;
      acc    <= '0;
      z_flag <= 1'b0;
      c_flag <= 1'b0;
      _out_  <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          ir    <= mem_rdata;
          pc    <= pc + 1'b1;
          state <= S_EXEC;
        end
        S_EXEC: begin
          state <= S_FETCH;
          if (acc_we) begin
            acc    <= alu_res;
            z_flag <= (alu_res == '0);
          end
          if (carry_we) c_flag <= alu_carry;
          case (opcode)
            OP_JMP: pc <= operand;
            OP_JZ:  if (z_flag) pc <= operand;
            OP_JC:  if (c_flag) pc <= operand;
            OP_OUT: _out_ <= acc;
            OP_HLT: state <= S_HALT;
            default: ;
          endcase
        end
        S_HALT: ;
        default: state <= S_FETCH;
      endcase
    end
  end

`ifdef SAP_DEBUG_EN
  assign debug = DW'({pc, opcode});
`else
  assign debug = '0;
`endif

endmodule

// File: tb/tb_sap16_core.sv
// Self-checking bench for sap16_core: instruction-level reference model compared every cycle,
// plus hand-computed expectations for Fibonacci, flags, halt, reset-during-STA and self-modifying code.

module tb_sap16_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] out_w;
  logic [15:0] debug_w;

  sap16_core dut (
    .clk   (clk),
    .rst   (rst),
    ._out_ (out_w),
    .debug (debug_w)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state advanced one whole instruction at a time.
  logic [15:0] m [256];
  logic [7:0]  m_pc;
  logic [7:0]  m_op;
  logic [15:0] m_a;
  logic [15:0] m_out;
  bit          m_z, m_c, m_halt;
  bit          did_out;
  logic [15:0] outs [$];
  int          cyc = 0;
  bit          rst_seen = 1'b1;

  task automatic model_reset();
    m_pc = 8'h0A; m_op = 8'h00; m_a = '0; m_out = '0;
    m_z = 1'b0; m_c = 1'b0; m_halt = 1'b0;
  endtask

  task automatic model_step();
    logic [15:0] ir, mv;
    logic [7:0]  n;
    int          s;
    did_out = 1'b0;
    if (m_halt) return;
    ir   = m[m_pc];
    m_pc = m_pc + 8'd1;
    m_op = ir[15:8];
    n    = ir[7:0];
    mv   = m[n];
    case (m_op)
      8'h00: begin m_a = mv;        m_z = (m_a == 0); end
      8'h01: m[n] = m_a;
      8'h02: begin
        s   = int'(m_a) + int'(mv);
        m_c = (s > 65535);
        m_a = 16'(s);
        m_z = (m_a == 0);
      end
      8'h03: begin
        m_c = (m_a >= mv);
        m_a = m_a - mv;
        m_z = (m_a == 0);
      end
      8'h04: begin m_a = m_a & mv;  m_z = (m_a == 0); end
      8'h05: begin m_a = m_a | mv;  m_z = (m_a == 0); end
      8'h06: begin m_a = m_a ^ mv;  m_z = (m_a == 0); end
      8'h07: begin m_a = {8'h00, n}; m_z = (m_a == 0); end
      8'h08: m_pc = n;
      8'h09: if (m_z) m_pc = n;
      8'h0A: if (m_c) m_pc = n;
      8'h0B: begin m_out = m_a; did_out = 1'b1; end
      8'hFF: m_halt = 1'b1;
      default: ;
    endcase
  endtask

  function automatic logic [15:0] exp_debug();
`ifdef SAP_DEBUG_EN
    return {m_pc, m_op};
`else
    return 16'h0000;
`endif
  endfunction

  always @(posedge clk) rst_seen <= rst;

  // Compare process: during reset and at every instruction boundary the whole state is checked;
  // acc, flags and _out_ only change at instruction boundaries so they are checked every cycle.
  always @(negedge clk) begin
    if (rst_seen) begin
      model_reset();
      cyc = 0;
      check("rst_pc", dut.pc, m_pc);
      check("rst_debug", debug_w, exp_debug());
    end else begin
      cyc++;
      if (cyc % 2 == 0) begin
        model_step();
        check("pc", dut.pc, m_pc);
        check("debug", debug_w, exp_debug());
        if (did_out) outs.push_back(out_w);
      end
    end
    check("acc", dut.acc, m_a);
    check("z", dut.z_flag, m_z);
    check("c", dut.c_flag, m_c);
    check("out", out_w, m_out);
  end

  task automatic load(input logic [7:0] a, input logic [15:0] v);
    dut.ram1.mem[a] <= v;
    m[a] = v;
  endtask

  task automatic enter_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic leave_reset();
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 256; i++) load(8'(i), 16'h0000);

    // Fibonacci program, reset behaviour and 16-bit wrap of the sequence.
    enter_reset();
    load(8'h00, 16'h0000); load(8'h01, 16'h0001);
    load(8'h0A, 16'h0000); load(8'h0B, 16'h0B00); load(8'h0C, 16'h0201);
    load(8'h0D, 16'h0102); load(8'h0E, 16'h0001); load(8'h0F, 16'h0100);
    load(8'h10, 16'h0002); load(8'h11, 16'h0101); load(8'h12, 16'h080A);
    run(1);
    check("reset_out", out_w, 16'h0000);
    check("reset_acc", dut.acc, 16'h0000);
`ifdef SAP_DEBUG_EN
    check("reset_debug", debug_w, 16'h0A00);
`endif
    outs.delete();
    leave_reset();
    run(1);
    check("first_cycle_out", out_w, 16'h0000);
    check("first_cycle_acc", dut.acc, 16'h0000);
    check("first_cycle_pc", dut.pc, 8'h0B);
    run(480);
    check("fib_count", outs.size() >= 26, 1'b1);
    if (outs.size() >= 26) begin
      check("fib_0", outs[0], 16'd0);
      check("fib_1", outs[1], 16'd1);
      check("fib_7", outs[7], 16'd13);
      check("fib_24", outs[24], 16'd46368);
      check("fib_25_wrap", outs[25], 16'h2511);
    end

    // LDI 5; SUB M(=5); JZ 20 -> zero, no borrow, jump taken to a HLT at 20.
    enter_reset();
    load(8'h0A, 16'h0705); load(8'h0B, 16'h0332); load(8'h0C, 16'h0914);
    load(8'h0D, 16'hFF00); load(8'h14, 16'hFF00); load(8'h32, 16'h0005);
    leave_reset();
    run(20);
    check("sub_eq_acc", dut.acc, 16'h0000);
    check("sub_eq_z", dut.z_flag, 1'b1);
    check("sub_eq_c", dut.c_flag, 1'b1);
    check("jz_taken_pc", dut.pc, 8'd21);

    // LDI 3; SUB M(=5) -> borrow.
    enter_reset();
    load(8'h0A, 16'h0703); load(8'h0B, 16'h0332); load(8'h0C, 16'hFF00);
    leave_reset();
    run(16);
    check("sub_borrow_acc", dut.acc, 16'hFFFE);
    check("sub_borrow_c", dut.c_flag, 1'b0);
    check("sub_borrow_pc", dut.pc, 8'd13);

    // HLT at 10 holds everything; one reset cycle restarts at 10.
    enter_reset();
    load(8'h0A, 16'hFF00);
    leave_reset();
    run(54);
    check("halt_pc", dut.pc, 8'd11);
    check("halt_state", dut.state, 2'd2);
    enter_reset();
    leave_reset();
    run(1);
    check("restart_pc", dut.pc, 8'd11);

    // Reset during the EXEC cycle of STA 30 with A=1234 suppresses the write.
    enter_reset();
    load(8'h0A, 16'h0028); load(8'h0B, 16'h011E); load(8'h0C, 16'hFF00);
    load(8'h1E, 16'hABCD); load(8'h28, 16'h1234);
    leave_reset();
    for (int i = 0; i < 20 && cyc != 3; i++) begin
      @(negedge clk); #1;
    end
    check("sta_reached", cyc, 32'd3);
    rst = 1'b1;
    @(negedge clk); #1;
    check("sta_suppressed", dut.ram1.mem[30], 16'hABCD);
    check("sta_rst_pc", dut.pc, 8'h0A);
    rst = 1'b0;
    run(12);
    check("sta_after_restart", dut.ram1.mem[30], 16'h1234);

    // STA onto the next instruction: the new word is what gets fetched.
    enter_reset();
    load(8'h0A, 16'h0028); load(8'h0B, 16'h010C); load(8'h0C, 16'h0B00);
    load(8'h28, 16'hFF00);
    leave_reset();
    run(20);
    check("selfmod_pc", dut.pc, 8'd13);
    check("selfmod_acc", dut.acc, 16'hFF00);
    check("selfmod_out", out_w, 16'h0000);

    // Logic ops, ADD carry, JC taken, NOP, OUT.
    enter_reset();
    load(8'h0A, 16'h07F0); load(8'h0B, 16'h0533); load(8'h0C, 16'h0434);
    load(8'h0D, 16'h0635); load(8'h0E, 16'h0236); load(8'h0F, 16'h0237);
    load(8'h10, 16'h0A18); load(8'h11, 16'hFF00);
    load(8'h18, 16'h0C55); load(8'h19, 16'h0B00); load(8'h1A, 16'hFF00);
    load(8'h33, 16'h0F0F); load(8'h34, 16'h00FF); load(8'h35, 16'h00FF);
    load(8'h36, 16'hFFFF); load(8'h37, 16'h0002);
    leave_reset();
    run(30);
    check("logic_pc", dut.pc, 8'd27);
    check("logic_out", out_w, 16'h0001);
    check("logic_c", dut.c_flag, 1'b1);
    check("logic_z", dut.z_flag, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
